// File: rtl/tt_temp_pkg.sv
// Shared definitions for the ring-oscillator temperature readout.
//   state_t   : conversion FSM encoding (IDLE, ARM, COUNT, LATCH)
//   WIN_BASE  : shortest gate window in clk cycles
//   win_len() : gate window length for a given win_sel code
package tt_temp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_COUNT = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   localparam int unsigned WIN_BASE = 16;

   // Window doubles per win_sel step: 16, 32, ... clk cycles.
   function automatic int unsigned win_len(input int unsigned sel);
      return WIN_BASE << sel;
   endfunction

endpackage

// File: rtl/temp_sensor_freq_counter_if.sv
// Control/result bus of the temperature-sensor frequency counter.
//   start, continuous, win_sel, div_ratio, ch_sel : control into the counter
//   result, ovf                                   : latched count/saturation of ch_sel
//   valid                                         : new-results strobe
//   busy                                          : conversion in progress
//   fsm_state                                     : live FSM state for observation
// Handshake: valid is a single-cycle strobe with no ready/back-pressure; it marks
// the first cycle in which freshly latched results are visible, and the results
// then hold until the next latch. start is a level sampled only while idle.
interface temp_sensor_freq_counter_if
   import tt_temp_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 12,
   parameter int WIN_W  = 3,
   parameter int DIV_W  = 8
) ();

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic             start;
   logic             continuous;
   logic [WIN_W-1:0] win_sel;
   logic [DIV_W-1:0] div_ratio;
   logic [SEL_W-1:0] ch_sel;
   logic [CNT_W-1:0] result;
   logic             ovf;
   logic             valid;
   logic             busy;
   state_t           fsm_state;

   modport master (
      output start, continuous, win_sel, div_ratio, ch_sel,
      input  result, ovf, valid, busy, fsm_state
   );

   modport slave (
      input  start, continuous, win_sel, div_ratio, ch_sel,
      output result, ovf, valid, busy, fsm_state
   );

endinterface

// File: rtl/osc_edge_sync.sv
// Brings one asynchronous ring-oscillator output into the clk domain and
// produces a one-cycle pulse per rising edge.
//   clk, rst_n : system clock, async active-low reset
//   osc        : asynchronous oscillator input
//   pulse      : one clk-cycle pulse per detected rising edge
// Oscillators faster than clk/2 alias and undercount; that is accepted.
module osc_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic osc,
   output logic pulse
);

   logic sync1_q;
   logic sync2_q;
   logic hist_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
      end else begin
         sync1_q <= osc;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
      end
   end

   assign pulse = sync2_q & ~hist_q;

endmodule

// File: rtl/temp_sensor_freq_counter.sv
// Parallel frequency counter for ring-oscillator temperature sensors plus a
// free-running programmable clock divider.
//   clk, rst_n  : system clock, async active-low reset
//   ena         : block enable; low aborts a conversion and stops the divider
//   osc_in      : NUM_CH asynchronous oscillator inputs
//   clk_div_out : divided clock, half-period = div_ratio+1 clk cycles
//   bus         : control/result bus (see temp_sensor_freq_counter_if)
module temp_sensor_freq_counter
   import tt_temp_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 12,
   parameter int WIN_W  = 3,
   parameter int DIV_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ena,
   input  logic [NUM_CH-1:0]          osc_in,
   output logic                       clk_div_out,
   temp_sensor_freq_counter_if.slave  bus
);

   // Wide enough to hold the longest window length itself.
   localparam int WLEN_W = $clog2(int'(WIN_BASE) << ((1 << WIN_W) - 1)) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   state_t              state_nx;
   logic [WLEN_W-1:0]   win_cnt;
   logic                cnt_clr;
   logic                valid_q;
   logic [CNT_W-1:0]    res_arr [NUM_CH];
   logic [NUM_CH-1:0]   ovf_arr;
   logic [DIV_W-1:0]    div_cnt;
   logic                div_q;

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:  if (bus.start) state_nx = ST_ARM;
         ST_ARM:   state_nx = ST_COUNT;
         ST_COUNT: if (win_cnt == WLEN_W'(1)) state_nx = ST_LATCH;
         ST_LATCH: state_nx = bus.continuous ? ST_ARM : ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
      if (!ena) state_nx = ST_IDLE;
   end

   // Window counter: loaded in ARM, so win_sel changes only apply at the next ARM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt <= '0;
      end else if (state == ST_ARM) begin
         win_cnt <= WLEN_W'(win_len({{(32-WIN_W){1'b0}}, bus.win_sel}));
      end else if (state == ST_COUNT) begin
         win_cnt <= win_cnt - 1'b1;
      end
   end

   assign cnt_clr = (state == ST_ARM) || !ena;

   // ---------------- per-channel counters ----------------
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic             pulse;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] res_q;
      logic             sat_q;
      logic             ovf_q;

      osc_edge_sync u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .osc   (osc_in[i]),
         .pulse (pulse)
      );

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
            res_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (cnt_clr) begin
               cnt_q <= '0;
               sat_q <= 1'b0;
            end else if ((state == ST_COUNT) && pulse) begin
               // Counter sticks at all-ones; an edge arriving there flags overflow.
               if (cnt_q == CNT_MAX) sat_q <= 1'b1;
               else                  cnt_q <= cnt_q + 1'b1;
            end
            if ((state == ST_LATCH) && ena) begin
               res_q <= cnt_q;
               ovf_q <= sat_q;
            end
         end
      end

      assign res_arr[i] = res_q;
      assign ovf_arr[i] = ovf_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= 1'b0;
      else        valid_q <= (state == ST_LATCH) && ena;
   end

   // Out-of-range ch_sel falls through to zero.
   always_comb begin
      bus.result = '0;
      bus.ovf    = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (int'(bus.ch_sel) == i) begin
            bus.result = res_arr[i];
            bus.ovf    = ovf_arr[i];
         end
      end
   end

   assign bus.valid     = valid_q;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.fsm_state = state;

   // ---------------- clock divider ----------------
   // ">=" rather than "==" so a ratio lowered below the current count wraps at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         div_q   <= 1'b0;
      end else if (!ena) begin
         div_cnt <= '0;
         div_q   <= 1'b0;
      end else if (div_cnt >= bus.div_ratio) begin
         div_cnt <= '0;
         div_q   <= ~div_q;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign clk_div_out = div_q;

endmodule

// File: tb/tb_temp_sensor_freq_counter.sv
// Bench for temp_sensor_freq_counter: two builds (4ch/12-bit and 3ch/4-bit)
// share all stimulus; a cycle-level window model predicts valid/busy/results.
module tb_temp_sensor_freq_counter;
   import tt_temp_pkg::*;

   localparam int CLK_P = 10;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [3:0] osc = '0;
   logic       start;
   logic       continuous;
   logic [2:0] win_sel;
   logic [7:0] div_ratio;
   logic [1:0] ch_sel;
   logic       div_a;
   logic       div_b;

   int checks = 0;
   int errors = 0;

   always #(CLK_P/2) clk = ~clk;

   temp_sensor_freq_counter_if #(.NUM_CH(4), .CNT_W(12), .WIN_W(3), .DIV_W(8)) if_a ();
   temp_sensor_freq_counter_if #(.NUM_CH(3), .CNT_W(4),  .WIN_W(3), .DIV_W(8)) if_b ();

   assign if_a.start = start;      assign if_b.start = start;
   assign if_a.continuous = continuous; assign if_b.continuous = continuous;
   assign if_a.win_sel = win_sel;  assign if_b.win_sel = win_sel;
   assign if_a.div_ratio = div_ratio; assign if_b.div_ratio = div_ratio;
   assign if_a.ch_sel = ch_sel;    assign if_b.ch_sel = ch_sel;

   temp_sensor_freq_counter #(.NUM_CH(4), .CNT_W(12), .WIN_W(3), .DIV_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .clk_div_out(div_a), .bus(if_a));
   temp_sensor_freq_counter #(.NUM_CH(3), .CNT_W(4), .WIN_W(3), .DIV_W(8)) u_b (
      .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc[2:0]), .clk_div_out(div_b), .bus(if_b));

   // ---------------- oscillator sources (half-period in clk cycles, 0 = off) ----------------
   int half [4] = '{4, 2, 0, 3};
   int ph   [4] = '{0, 0, 0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (half[i] != 0) begin
            ph[i] = ph[i] + 1;
            if (ph[i] >= half[i]) begin
               ph[i]  = 0;
               osc[i] = ~osc[i];
            end
         end else begin
            osc[i] = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   // o_hist[c] is the oscillator value the DUT samples at the end of cycle c.
   // A window started in cycle k counts rising transitions at cycles k..k+W-1,
   // ends with results visible and valid in cycle k+W+3.
   logic [3:0] o_hist [8192];
   int  cyc = 0;
   bit  m_active = 0;
   int  m_k = 0;
   int  m_w = 0;
   bit  exp_valid = 0;
   bit  exp_busy = 0;
   bit  exp_div_zero = 1;
   int  exp_res_a [4] = '{0, 0, 0, 0};
   bit  exp_ovf_a [4] = '{0, 0, 0, 0};
   int  exp_res_b [3] = '{0, 0, 0};
   bit  exp_ovf_b [3] = '{0, 0, 0};

   function automatic int edges(int ch, int k, int w);
      int n = 0;
      for (int c = k; c < k + w; c++)
         if (o_hist[c][ch] && !o_hist[c-1][ch]) n++;
      return n;
   endfunction

   task automatic latch_model();
      int n;
      for (int ch = 0; ch < 4; ch++) begin
         n = edges(ch, m_k, m_w);
         exp_res_a[ch] = (n > 4095) ? 4095 : n;
         exp_ovf_a[ch] = (n > 4095);
         if (ch < 3) begin
            exp_res_b[ch] = (n > 15) ? 15 : n;
            exp_ovf_b[ch] = (n > 15);
         end
      end
   endtask

   always @(posedge clk) begin
      int c;
      c = cyc;
      if (c < 8192) o_hist[c] = rst_n ? osc : 4'b0;
      if (!rst_n) begin
         m_active = 0;
         exp_valid = 0;
         exp_div_zero = 1;
         for (int i = 0; i < 4; i++) begin exp_res_a[i] = 0; exp_ovf_a[i] = 0; end
         for (int i = 0; i < 3; i++) begin exp_res_b[i] = 0; exp_ovf_b[i] = 0; end
      end else begin
         exp_valid = 0;
         exp_div_zero = !ena;
         if (!ena) begin
            m_active = 0;
         end else if (!m_active) begin
            if (start) begin m_active = 1; m_k = c; m_w = 0; end
         end else if (c == m_k + 1) begin
            m_w = 16 << win_sel;
         end else if (c == m_k + m_w + 2) begin
            latch_model();
            exp_valid = 1;
            if (continuous) m_k = c;
            else            m_active = 0;
         end
      end
      exp_busy = m_active;
      cyc = cyc + 1;
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      #1;
      chk("valid_a", 32'(if_a.valid), 32'(exp_valid));
      chk("valid_b", 32'(if_b.valid), 32'(exp_valid));
      chk("busy_a",  32'(if_a.busy),  32'(exp_busy));
      chk("busy_b",  32'(if_b.busy),  32'(exp_busy));
      chk("result_a", 32'(if_a.result), 32'(exp_res_a[ch_sel]));
      chk("ovf_a",    32'(if_a.ovf),    32'(exp_ovf_a[ch_sel]));
      chk("result_b", 32'(if_b.result), (ch_sel < 3) ? 32'(exp_res_b[ch_sel]) : 32'd0);
      chk("ovf_b",    32'(if_b.ovf),    (ch_sel < 3) ? 32'(exp_ovf_b[ch_sel]) : 32'd0);
      if (exp_div_zero) begin
         chk("div_a_off", 32'(div_a), 32'd0);
         chk("div_b_off", 32'(div_b), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_start(output int k);
      start = 1'b1;
      k = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
   endtask

   task automatic wait_valid(output int at, input int budget);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         if (if_a.valid) begin at = cyc; break; end
         @(negedge clk);
      end
      if (at < 0) timeout_fail("wait_valid");
   endtask

   task automatic count_valids(input int budget, output int n, output int last);
      n = 0;
      last = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (if_a.valid) begin n++; last = cyc; end
      end
   endtask

   task automatic wait_div_rise(output int at);
      logic prev;
      at = -1;
      prev = div_a;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (div_a && !prev) begin at = cyc; break; end
         prev = div_a;
      end
      if (at < 0) timeout_fail("div_rise");
   endtask

   task automatic measure_period(output int p);
      int a, b;
      wait_div_rise(a);
      wait_div_rise(b);
      p = b - a;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int k, v, v1, v2, v3, n, last, p;
      logic d0;
      rst_n = 1'b0; ena = 1'b1; start = 1'b0; continuous = 1'b0;
      win_sel = '0; div_ratio = '0; ch_sel = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid",  32'(if_a.valid),  32'd0);
      chk("rst_busy",   32'(if_a.busy),   32'd0);
      chk("rst_result", 32'(if_a.result), 32'd0);
      chk("rst_div",    32'(div_a),       32'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // 1: single 16-cycle window, ch0 at clk/8, ch1 at clk/4
      win_sel = 3'd0;
      do_start(k);
      wait_valid(v, 60);
      chk("t1_latency", 32'(v - k), 32'd19);
      ch_sel = 2'd0; #1;
      chk("t1_ch0", 32'(if_a.result), 32'd2);
      ch_sel = 2'd1; #1;
      chk("t1_ch1", 32'(if_a.result), 32'd4);
      @(negedge clk);

      // 2: 128-cycle window, 4-bit build saturates on ch1, ch2 idle, ch3 out of range
      win_sel = 3'd3;
      do_start(k);
      wait_valid(v, 200);
      chk("t2_latency", 32'(v - k), 32'd131);
      ch_sel = 2'd1; #1;
      chk("t2_a_ch1", 32'(if_a.result), 32'd32);
      chk("t2_a_ovf", 32'(if_a.ovf), 32'd0);
      chk("t2_b_ch1", 32'(if_b.result), 32'd15);
      chk("t2_b_ovf", 32'(if_b.ovf), 32'd1);
      ch_sel = 2'd2; #1;
      chk("t2_b_ch2", 32'(if_b.result), 32'd0);
      chk("t2_b_ch2_ovf", 32'(if_b.ovf), 32'd0);
      ch_sel = 2'd3; #1;
      chk("t2_b_oor", 32'(if_b.result), 32'd0);
      chk("t2_b_oor_ovf", 32'(if_b.ovf), 32'd0);
      @(negedge clk);
      ch_sel = 2'd0;

      // 3: continuous windows, then drop continuous mid-window
      win_sel = 3'd0;
      continuous = 1'b1;
      do_start(k);
      wait_valid(v1, 60);
      @(negedge clk);
      wait_valid(v2, 60);
      @(negedge clk);
      wait_valid(v3, 60);
      chk("t3_first", 32'(v1 - k), 32'd19);
      chk("t3_period1", 32'(v2 - v1), 32'd18);
      chk("t3_period2", 32'(v3 - v2), 32'd18);
      repeat (5) @(negedge clk);
      continuous = 1'b0;
      count_valids(60, n, last);
      chk("t3_tail_count", 32'(n), 32'd1);
      chk("t3_tail_at", 32'(last - v3), 32'd18);
      chk("t3_idle", 32'(if_a.busy), 32'd0);

      // 4: abort by ena low during COUNT
      win_sel = 3'd1;
      do_start(k);
      repeat (10) @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      chk("t4_busy_drop", 32'(if_a.busy), 32'd0);
      ena = 1'b1;
      count_valids(60, n, last);
      chk("t4_no_valid", 32'(n), 32'd0);
      chk("t4_kept", 32'(if_a.result), 32'd2);

      // 5: divider periods and mid-period ratio reduction
      div_ratio = 8'd0;
      measure_period(p);
      chk("t5_ratio0", 32'(p), 32'd2);
      div_ratio = 8'd3;
      measure_period(p);
      chk("t5_ratio3", 32'(p), 32'd8);
      div_ratio = 8'd200;
      wait_div_rise(v);
      repeat (100) @(negedge clk);
      div_ratio = 8'd5;
      d0 = div_a;
      n = -1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (div_a != d0) begin n = i; break; end
      end
      chk("t5_wrap_now", 32'(n), 32'd1);
      measure_period(p);
      chk("t5_ratio5", 32'(p), 32'd12);

      // 6: async reset mid-COUNT, then a normal conversion
      win_sel = 3'd2;
      do_start(k);
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy",   32'(if_a.busy),   32'd0);
      chk("t6_valid",  32'(if_a.valid),  32'd0);
      chk("t6_result", 32'(if_a.result), 32'd0);
      chk("t6_result_b", 32'(if_b.result), 32'd0);
      chk("t6_div",    32'(div_a),       32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      win_sel = 3'd0;
      do_start(k);
      wait_valid(v, 60);
      chk("t6_latency", 32'(v - k), 32'd19);
      chk("t6_ch0", 32'(if_a.result), 32'd2);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected end of sequence");
      $fatal(1, "watchdog expired");
   end

endmodule
